mlp_train_sequencer: RTL and testbench

MLP_TRAIN_SEQUENCER -- requirements
Module: mlp_train_sequencer

---
 rtl/mlp_train_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_mlp_train_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_train_sequencer.sv
// Training sequencer: streams a sample store through an MLP, one training window per sample,
// accumulating |expected - prediction| per epoch. Define MLP_EARLY_STOP_EN to stop early on err_threshold.
module mlp_train_sequencer #(
   parameter int inputs        = 2,
   parameter int outputs       = 1,
   parameter int samples       = 4,
   parameter int settle_cycles = 2,
   parameter int epochs        = 1000
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          load_valid,
   input  logic [((samples > 1) ? $clog2(samples) : 1)-1:0] load_addr,
   input  logic [inputs*16-1:0]                          load_values,
   input  logic [outputs*16-1:0]                         load_expected,
   input  logic                                          start,
   input  logic                                          abort,
   input  logic [15:0]                                   lr_in,
   input  logic [15:0]                                   err_threshold,
   output logic [inputs*16-1:0]                          values,
   output logic [outputs*16-1:0]                         expected,
   output logic                                          training,
   output logic [15:0]                                   learning_rate,
   input  logic [outputs*16-1:0]                         prediction,
   output logic                                          busy,
   output logic                                          done,
   output logic [31:0]                                   epoch_count,
   output logic [15:0]                                   epoch_error
);
   localparam int SW = 16;
   localparam int AW = (samples > 1) ? $clog2(samples) : 1;
   localparam int CW = (settle_cycles > 1) ? $clog2(settle_cycles) : 1;
   localparam logic [SW-1:0] SFP_MAX = 16'h7FFF;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_APPLY   = 3'd1;
   localparam logic [2:0] S_SETTLE  = 3'd2;
   localparam logic [2:0] S_CAPTURE = 3'd3;
   localparam logic [2:0] S_NEXT    = 3'd4;
   localparam logic [2:0] S_FINISH  = 3'd5;

   logic [inputs*SW-1:0]  feat_mem [samples];
   logic [outputs*SW-1:0] tgt_mem  [samples];

   logic [2:0]             state_q, state_d;
   logic [AW-1:0]          index_q, index_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [SW-1:0]          acc_q, acc_d;
   logic [31:0]            epoch_count_q, epoch_count_d;
   logic [SW-1:0]          epoch_error_q, epoch_error_d;
   logic [SW-1:0]          lr_q, lr_d;
   logic                   training_q, training_d;
   logic [inputs*SW-1:0]   values_q;
   logic [outputs*SW-1:0]  expected_q;

   logic                   load_next;
   logic [AW-1:0]          rd_addr;
   logic                   last_sample;
   logic                   early_stop;
   logic [SW:0]            absdiff [outputs];
   logic [31:0]            err_sum;
   logic [SW-1:0]          acc_sat;

   // Per-output absolute error, done in one extra bit so the subtraction cannot overflow.
   for (genvar gi = 0; gi < outputs; gi++) begin : g_err
      logic signed [SW:0] exp_ext;
      logic signed [SW:0] pred_ext;
      logic signed [SW:0] diff;
      assign exp_ext    = {expected_q[gi*SW+SW-1], expected_q[gi*SW +: SW]};
      assign pred_ext   = {prediction[gi*SW+SW-1], prediction[gi*SW +: SW]};
      assign diff       = exp_ext - pred_ext;
      assign absdiff[gi] = diff[SW] ? -diff : diff;
   end

   always_comb begin
      err_sum = {16'd0, acc_q};
      for (int i = 0; i < outputs; i++) begin
         err_sum = err_sum + {15'd0, absdiff[i]};
      end
      acc_sat = (err_sum > {16'd0, SFP_MAX}) ? SFP_MAX : err_sum[SW-1:0];
   end

   assign last_sample = (index_q == AW'(samples - 1));

`ifdef MLP_EARLY_STOP_EN
   assign early_stop = ($signed(acc_q) < $signed(err_threshold));
`else
   logic unused_thresh;
   assign unused_thresh = ^err_threshold;
   assign early_stop    = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      index_d       = index_q;
      cnt_d         = cnt_q;
      acc_d         = acc_q;
      epoch_count_d = epoch_count_q;
      epoch_error_d = epoch_error_q;
      lr_d          = lr_q;
      training_d    = training_q;
      load_next     = 1'b0;
      rd_addr       = index_q;
      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               lr_d          = lr_in;
               index_d       = '0;
               epoch_count_d = '0;
               acc_d         = '0;
               rd_addr       = '0;
               load_next     = 1'b1;
               training_d    = 1'b1;
               state_d       = S_APPLY;
            end
         end
         S_APPLY: begin
            cnt_d   = CW'(settle_cycles - 1);
            state_d = S_SETTLE;
         end
         S_SETTLE: begin
            if (cnt_q == '0) begin
               training_d = 1'b0;
               state_d    = S_CAPTURE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_CAPTURE: begin
            acc_d   = acc_sat;
            state_d = S_NEXT;
         end
         S_NEXT: begin
            if (last_sample) begin
               epoch_error_d = acc_q;
               epoch_count_d = epoch_count_q + 32'd1;
               acc_d         = '0;
               index_d       = '0;
               if ((epoch_count_q + 32'd1 == 32'(epochs)) || early_stop) begin
                  state_d = S_FINISH;
               end else begin
                  rd_addr    = '0;
                  load_next  = 1'b1;
                  training_d = 1'b1;
                  state_d    = S_APPLY;
               end
            end else begin
               index_d    = index_q + AW'(1);
               rd_addr    = index_q + AW'(1);
               load_next  = 1'b1;
               training_d = 1'b1;
               state_d    = S_APPLY;
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
      // Abort wins over everything, including an epoch rollover in NEXT.
      if (abort && state_q != S_IDLE) begin
         state_d       = S_IDLE;
         training_d    = 1'b0;
         load_next     = 1'b0;
         epoch_count_d = epoch_count_q;
         epoch_error_d = epoch_error_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         index_q       <= '0;
         cnt_q         <= '0;
         acc_q         <= '0;
         epoch_count_q <= '0;
         epoch_error_q <= '0;
         lr_q          <= '0;
         training_q    <= 1'b0;
         values_q      <= '0;
         expected_q    <= '0;
      end else begin
         state_q       <= state_d;
         index_q       <= index_d;
         cnt_q         <= cnt_d;
         acc_q         <= acc_d;
         epoch_count_q <= epoch_count_d;
         epoch_error_q <= epoch_error_d;
         lr_q          <= lr_d;
         training_q    <= training_d;
         if (load_next) begin
            values_q   <= feat_mem[rd_addr];
            expected_q <= tgt_mem[rd_addr];
         end
      end
   end

   // Store is deliberately left out of reset so it survives a mid-run rst.
   always_ff @(posedge clk) begin
      if (load_valid && state_q == S_IDLE && 32'(load_addr) < samples) begin
         feat_mem[load_addr] <= load_values;
         tgt_mem[load_addr]  <= load_expected;
      end
   end

   assign values        = values_q;
   assign expected      = expected_q;
   assign training      = training_q;
   assign learning_rate = lr_q;
   assign busy          = (state_q != S_IDLE);
   assign done          = (state_q == S_FINISH);
   assign epoch_count   = epoch_count_q;
   assign epoch_error   = epoch_error_q;
endmodule

// File: tb/tb_mlp_train_sequencer.sv
// Directed bench for mlp_train_sequencer: a scoreboard of expected training windows is checked
// against values/expected seen at each training rise; run-level results are checked at done.
module tb_mlp_train_sequencer;
   localparam int INPUTS  = 2;
   localparam int OUTPUTS = 1;
   localparam int SAMPLES = 4;
   localparam int SETTLE  = 2;
   localparam int EPOCHS  = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_valid;
   logic [1:0]  load_addr;
   logic [31:0] load_values;
   logic [15:0] load_expected;
   logic        start;
   logic        abort;
   logic [15:0] lr_in;
   logic [15:0] err_threshold;
   logic [31:0] values;
   logic [15:0] expected;
   logic        training;
   logic [15:0] learning_rate;
   logic [15:0] prediction;
   logic        busy;
   logic        done;
   logic [31:0] epoch_count;
   logic [15:0] epoch_error;

   mlp_train_sequencer #(
      .inputs(INPUTS), .outputs(OUTPUTS), .samples(SAMPLES),
      .settle_cycles(SETTLE), .epochs(EPOCHS)
   ) dut (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_addr(load_addr),
      .load_values(load_values), .load_expected(load_expected), .start(start),
      .abort(abort), .lr_in(lr_in), .err_threshold(err_threshold), .values(values),
      .expected(expected), .training(training), .learning_rate(learning_rate),
      .prediction(prediction), .busy(busy), .done(done), .epoch_count(epoch_count),
      .epoch_error(epoch_error)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int windows = 0;
   int win_len = 0;
   logic train_prev = 1'b0;
   logic skip_len = 1'b0;
   logic mode_es = 1'b0;
   logic [47:0] sb_q [$];
   logic [47:0] sb_e;
   logic [15:0] feat [SAMPLES][INPUTS];
   logic [15:0] tgt [SAMPLES];

   // Network stand-in: constant 0.5, or (early-stop mode, from epoch 2) target + 0.125.
   always_comb prediction = (mode_es && epoch_count >= 32'd1) ? expected + 16'h0020 : 16'h0080;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         win_len    = 0;
         train_prev = 1'b0;
      end else begin
         if (training && !train_prev) begin
            windows++;
            checks++;
            assert (sb_q.size() != 0) else begin
               errors++;
               $error("FAIL sb_underflow: observed empty queue expected an entry");
            end
            if (sb_q.size() != 0) begin
               sb_e = sb_q.pop_front();
               check("window_values", 64'(values), 64'(sb_e[47:16]));
               check("window_expected", 64'(expected), 64'(sb_e[15:0]));
            end
         end
         if (training) begin
            win_len++;
         end else if (train_prev) begin
            if (!skip_len) check("window_len", 64'(win_len), 64'd3);
            skip_len = 1'b0;
            win_len  = 0;
         end
         train_prev = training;
      end
   end

   task automatic tick();
      @(negedge clk);
      cyc++;
   endtask

   task automatic push_run(input int n_epochs);
      for (int e = 0; e < n_epochs; e++)
         for (int s = 0; s < SAMPLES; s++)
            sb_q.push_back({feat[s][1], feat[s][0], tgt[s]});
   endtask

   task automatic pulse_start(input string tag);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      check({tag, "_busy_rise"}, 64'(busy), 64'd1);
   endtask

   task automatic run_until_done(input string tag, input int exp_cycles);
      while (!done && cyc < 500) tick();
      check({tag, "_done_cycle"}, 64'(cyc), 64'(exp_cycles));
      tick();
      check({tag, "_done_pulse"}, 64'(done), 64'd0);
      check({tag, "_busy_drop"}, 64'(busy), 64'd0);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_values"}, 64'(values), 64'd0);
      check({tag, "_expected"}, 64'(expected), 64'd0);
      check({tag, "_lr"}, 64'(learning_rate), 64'd0);
      check({tag, "_epoch_error"}, 64'(epoch_error), 64'd0);
      check({tag, "_training"}, 64'(training), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_epoch_count"}, 64'(epoch_count), 64'd0);
   endtask

   initial begin
      logic saw_done;
      int w0;
      rst = 1'b1; load_valid = 1'b0; load_addr = '0; load_values = '0; load_expected = '0;
      start = 1'b0; abort = 1'b0; lr_in = '0; err_threshold = '0;
      // XOR truth table in Q8.8 (1.0 = 0x0100).
      feat[0][0] = 16'h0000; feat[0][1] = 16'h0000; tgt[0] = 16'h0000;
      feat[1][0] = 16'h0000; feat[1][1] = 16'h0100; tgt[1] = 16'h0100;
      feat[2][0] = 16'h0100; feat[2][1] = 16'h0000; tgt[2] = 16'h0100;
      feat[3][0] = 16'h0100; feat[3][1] = 16'h0100; tgt[3] = 16'h0000;
      @(negedge clk); @(negedge clk);
      check_zero_outputs("reset");
      rst = 1'b0;

      for (int s = 0; s < SAMPLES; s++) begin
         @(negedge clk);
         load_valid = 1'b1; load_addr = 2'(s);
         load_values = {feat[s][1], feat[s][0]}; load_expected = tgt[s];
      end
      @(negedge clk);
      load_valid = 1'b0;

      // Full run: 3 epochs x 4 samples x 5 cycles + FINISH.
      lr_in = 16'h0033;
      push_run(EPOCHS);
      w0 = windows;
      pulse_start("run1");
      lr_in = 16'h7777;
      run_until_done("run1", 61);
      check("run1_epoch_count", 64'(epoch_count), 64'd3);
      check("run1_epoch_error", 64'(epoch_error), 64'h0200);
      check("run1_lr_latched", 64'(learning_rate), 64'h0033);
      check("run1_windows", 64'(windows - w0), 64'd12);
      check("run1_sb_empty", 64'(sb_q.size()), 64'd0);

      // Load and start while busy must change nothing.
      push_run(EPOCHS);
      w0 = windows;
      pulse_start("run2");
      while (cyc < 8) tick();
      load_valid = 1'b1; load_addr = 2'd1; load_values = 32'hDEAD_BEEF; load_expected = 16'h7F00;
      start = 1'b1;
      tick();
      load_valid = 1'b0; start = 1'b0;
      run_until_done("run2", 61);
      check("run2_epoch_count", 64'(epoch_count), 64'd3);
      check("run2_windows", 64'(windows - w0), 64'd12);

      // Abort in the first SETTLE cycle of sample 2, epoch 2 (cycle 32).
      push_run(EPOCHS);
      pulse_start("run3");
      while (cyc < 32) tick();
      skip_len = 1'b1;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_training", 64'(training), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_epoch_count", 64'(epoch_count), 64'd1);
      check("abort_epoch_error", 64'(epoch_error), 64'h0200);
      saw_done = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         saw_done = saw_done | done;
      end
      check("abort_no_done", 64'(saw_done), 64'd0);
      sb_q.delete();

      // Asynchronous reset in CAPTURE of sample 0, away from any clock edge.
      push_run(EPOCHS);
      pulse_start("run4");
      while (cyc < 4) tick();
      #2 rst = 1'b1;
      #1 check_zero_outputs("midrst");
      @(negedge clk);
      rst = 1'b0;
      sb_q.delete();

      lr_in = 16'h0040;
      push_run(EPOCHS);
      w0 = windows;
      pulse_start("run5");
      run_until_done("run5", 61);
      check("run5_epoch_count", 64'(epoch_count), 64'd3);
      check("run5_epoch_error", 64'(epoch_error), 64'h0200);
      check("run5_lr", 64'(learning_rate), 64'h0040);
      check("run5_windows", 64'(windows - w0), 64'd12);

`ifdef MLP_EARLY_STOP_EN
      // Epoch errors 2.0 then 0.5 against a 1.0 threshold: stop after epoch 2.
      err_threshold = 16'h0100;
      mode_es = 1'b1;
      push_run(2);
      pulse_start("es");
      run_until_done("es", 41);
      check("es_epoch_count", 64'(epoch_count), 64'd2);
      check("es_epoch_error", 64'(epoch_error), 64'h0080);
      check("es_sb_empty", 64'(sb_q.size()), 64'd0);
      mode_es = 1'b0;
      err_threshold = '0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
